// File: rtl/hpm_pkg.sv
// Shared constants, event-register layout and address helper for the HPM unit.
package hpm_pkg;

   localparam int unsigned HPM_FIRST = 3;

   localparam logic [1:0] PRV_U = 2'd0;
   localparam logic [1:0] PRV_S = 2'd1;
   localparam logic [1:0] PRV_M = 2'd3;

   // Group bases: the counter index lives in addr[4:0].
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] MHPMEVENT_BASE    = 12'h320;
   localparam logic [11:0] MHPMEVENTH_BASE   = 12'h720;
   localparam logic [11:0] MHPMCOUNTER_BASE  = 12'hB00;
   localparam logic [11:0] MHPMCOUNTERH_BASE = 12'hB80;
   localparam logic [11:0] HPMCOUNTER_BASE   = 12'hC00;
   localparam logic [11:0] HPMCOUNTERH_BASE  = 12'hC80;

   localparam int unsigned EVT_SEL_W = 8;
   localparam int unsigned EVT_UINH  = 60;
   localparam int unsigned EVT_SINH  = 61;
   localparam int unsigned EVT_MINH  = 62;
   localparam int unsigned EVT_OF    = 63;

   typedef struct packed {
      logic        of;
      logic        minh;
      logic        sinh;
      logic        uinh;
      logic [51:0] rsvd;
      logic [7:0]  sel;
   } hpm_evt_t;

   function automatic logic is_hpm_addr(input logic [11:0] addr);
      logic [11:0] base;
      base = {addr[11:5], 5'd0};
      if (addr == CSR_MCOUNTINHIBIT) return 1'b1;
      if (addr[4:0] < 5'(HPM_FIRST)) return 1'b0;
      return (base == MHPMEVENT_BASE)   || (base == MHPMEVENTH_BASE)   ||
             (base == MHPMCOUNTER_BASE) || (base == MHPMCOUNTERH_BASE) ||
             (base == HPMCOUNTER_BASE)  || (base == HPMCOUNTERH_BASE);
   endfunction

endpackage

// File: rtl/hpm_ctr.sv
// One programmable event counter with its mhpmevent register: filtering,
// CSR write priority over increment, and sticky overflow.
module hpm_ctr
   import hpm_pkg::*;
#(
   parameter int unsigned NUM_EVT = 16,
   parameter int unsigned CNT_W   = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rv32,
   input  logic [1:0]         prv,
   input  logic [NUM_EVT-1:0] evt,
   input  logic               inhibit,
   input  logic               wr_evt,
   input  logic               wr_evth,
   input  logic               wr_cnt,
   input  logic               wr_cnth,
   input  logic [63:0]        wdata,
   output hpm_evt_t           evt_cfg,
   output logic [CNT_W-1:0]   cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       sel_q, sel_d;
   logic             uinh_q, uinh_d, sinh_q, sinh_d, minh_q, minh_d, of_q, of_d;
   logic             hit, mode_inh, inc, wrap;

   // sel=0 and sel>NUM_EVT match no event line.
   always_comb begin
      hit = 1'b0;
      for (int e = 0; e < int'(NUM_EVT); e++) begin
         if (int'(sel_q) == e + 1) hit = evt[e];
      end
   end

   always_comb begin
      case (prv)
         PRV_U:   mode_inh = uinh_q;
         PRV_S:   mode_inh = sinh_q;
         default: mode_inh = minh_q;
      endcase
   end

   assign inc  = hit && !inhibit && !mode_inh && !wr_cnt && !wr_cnth;
   assign wrap = inc && (cnt_q == '1);

   always_comb begin
      cnt_d  = cnt_q;
      sel_d  = sel_q;
      uinh_d = uinh_q;
      sinh_d = sinh_q;
      minh_d = minh_q;
      of_d   = of_q | wrap;
      if (wr_cnt) begin
         if (rv32) cnt_d[31:0] = wdata[31:0];
         else      cnt_d       = wdata[CNT_W-1:0];
      end else if (wr_cnth) begin
         cnt_d[CNT_W-1:32] = wdata[CNT_W-33:0];
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // A written OF value overrides an overflow in the same cycle.
      if (wr_evt) begin
         sel_d = wdata[EVT_SEL_W-1:0];
         if (!rv32) {of_d, minh_d, sinh_d, uinh_d} = wdata[EVT_OF:EVT_UINH];
      end
      if (wr_evth) {of_d, minh_d, sinh_d, uinh_d} = wdata[EVT_OF-32:EVT_UINH-32];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sel_q  <= '0;
         uinh_q <= 1'b0;
         sinh_q <= 1'b0;
         minh_q <= 1'b0;
         of_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sel_q  <= sel_d;
         uinh_q <= uinh_d;
         sinh_q <= sinh_d;
         minh_q <= minh_d;
         of_q   <= of_d;
      end
   end

   always_comb begin
      evt_cfg      = '0;
      evt_cfg.of   = of_q;
      evt_cfg.minh = minh_q;
      evt_cfg.sinh = sinh_q;
      evt_cfg.uinh = uinh_q;
      evt_cfg.sel  = sel_q;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hpm_unit.sv
// Programmable HPM counters beside the base PMU: owns mcountinhibit, the HPM
// CSR read mux, access legality and the overflow interrupt.
module hpm_unit
   import hpm_pkg::*;
#(
   parameter int unsigned NUM_HPM = 4,
   parameter int unsigned NUM_EVT = 16,
   parameter int unsigned CNT_W   = 64
) (
   input  logic               clk_free,
   input  logic               rst,
   input  logic               rv32,
   input  logic [1:0]         prv,
   input  logic [NUM_EVT-1:0] evt,
   input  logic [31:0]        mcounteren,
   input  logic [31:0]        scounteren,
   input  logic               csr_rd_chk,
   input  logic               csr_wr_chk,
   input  logic               csr_wr,
   input  logic [11:0]        csr_waddr,
   input  logic [11:0]        csr_raddr,
   input  logic [63:0]        csr_wdata,
   output logic [63:0]        csr_rdata,
   output logic               csr_ill,
   output logic               inh_cy,
   output logic               inh_ir,
   output logic               ovf_irq
);

   localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << HPM_FIRST);

   logic [31:0]        inh_q;
   logic [CNT_W-1:0]   cnt     [NUM_HPM];
   hpm_evt_t           evt_cfg [NUM_HPM];
   logic [NUM_HPM-1:0] of_vec;

   always_ff @(posedge clk_free) begin
      if (rst) inh_q <= '0;
      else if (csr_wr && csr_waddr == CSR_MCOUNTINHIBIT) inh_q <= csr_wdata[31:0] & INH_MASK;
   end

   for (genvar i = 0; i < NUM_HPM; i++) begin : g_ctr
      localparam logic [11:0] IDX = 12'(HPM_FIRST + i);
      hpm_ctr #(
         .NUM_EVT (NUM_EVT),
         .CNT_W   (CNT_W)
      ) u_ctr (
         .clk     (clk_free),
         .rst     (rst),
         .rv32    (rv32),
         .prv     (prv),
         .evt     (evt),
         .inhibit (inh_q[HPM_FIRST+i]),
         .wr_evt  (csr_wr && csr_waddr == (MHPMEVENT_BASE | IDX)),
         .wr_evth (csr_wr && rv32 && csr_waddr == (MHPMEVENTH_BASE | IDX)),
         .wr_cnt  (csr_wr && csr_waddr == (MHPMCOUNTER_BASE | IDX)),
         .wr_cnth (csr_wr && rv32 && csr_waddr == (MHPMCOUNTERH_BASE | IDX)),
         .wdata   (csr_wdata),
         .evt_cfg (evt_cfg[i]),
         .cnt     (cnt[i])
      );
      assign of_vec[i] = evt_cfg[i].of;
   end

   // Unimplemented indices fall through to zero.
   always_comb begin
      logic [11:0] rbase;
      rbase     = {csr_raddr[11:5], 5'd0};
      csr_rdata = '0;
      if (csr_raddr == CSR_MCOUNTINHIBIT) csr_rdata = {32'd0, inh_q};
      for (int i = 0; i < int'(NUM_HPM); i++) begin
         if (int'(csr_raddr[4:0]) == int'(HPM_FIRST) + i) begin
            if (rbase == MHPMEVENT_BASE)  csr_rdata = evt_cfg[i];
            if (rbase == MHPMEVENTH_BASE) csr_rdata = {32'd0, evt_cfg[i][63:32]};
            if (rbase == MHPMCOUNTER_BASE || rbase == HPMCOUNTER_BASE)
               csr_rdata = 64'(cnt[i]);
            if (rbase == MHPMCOUNTERH_BASE || rbase == HPMCOUNTERH_BASE)
               csr_rdata = 64'(cnt[i] >> 32);
         end
      end
   end

   always_comb begin
      logic [11:0] wbase;
      logic        hi, usr;
      wbase   = {csr_waddr[11:5], 5'd0};
      hi      = (wbase == MHPMEVENTH_BASE) || (wbase == MHPMCOUNTERH_BASE) ||
                (wbase == HPMCOUNTERH_BASE);
      usr     = (wbase == HPMCOUNTER_BASE) || (wbase == HPMCOUNTERH_BASE);
      csr_ill = 1'b0;
      if ((csr_rd_chk || csr_wr_chk) && is_hpm_addr(csr_waddr)) begin
         if (hi && !rv32) csr_ill = 1'b1;
         if (usr) begin
            if (csr_wr_chk) csr_ill = 1'b1;
            if (prv != PRV_M && !mcounteren[csr_waddr[4:0]]) csr_ill = 1'b1;
            if (prv == PRV_U && !scounteren[csr_waddr[4:0]]) csr_ill = 1'b1;
         end else if (prv != PRV_M) begin
            csr_ill = 1'b1;
         end
      end
   end

   assign inh_cy  = inh_q[0];
   assign inh_ir  = inh_q[2];
   assign ovf_irq = |of_vec;

endmodule

// File: tb/tb_hpm_unit.sv
// Scoreboard bench for hpm_unit: directed scenarios then randomised traffic,
// all checked against a behavioural model of the HPM CSR state.
module tb_hpm_unit;
   localparam int NUM_HPM = 4;
   localparam int NUM_EVT = 16;
   localparam int CNT_W   = 64;

   logic               clk_free = 1'b0;
   logic               rst = 1'b1;
   logic               rv32 = 1'b0;
   logic [1:0]         prv = 2'd3;
   logic [NUM_EVT-1:0] evt = '0;
   logic [31:0]        mcounteren = '0, scounteren = '0;
   logic               csr_rd_chk = 1'b0, csr_wr_chk = 1'b0, csr_wr = 1'b0;
   logic [11:0]        csr_waddr = '0, csr_raddr = '0;
   logic [63:0]        csr_wdata = '0;
   logic [63:0]        csr_rdata;
   logic               csr_ill, inh_cy, inh_ir, ovf_irq;

   hpm_unit #(.NUM_HPM(NUM_HPM), .NUM_EVT(NUM_EVT), .CNT_W(CNT_W)) dut (
      .clk_free   (clk_free),
      .rst        (rst),
      .rv32       (rv32),
      .prv        (prv),
      .evt        (evt),
      .mcounteren (mcounteren),
      .scounteren (scounteren),
      .csr_rd_chk (csr_rd_chk),
      .csr_wr_chk (csr_wr_chk),
      .csr_wr     (csr_wr),
      .csr_waddr  (csr_waddr),
      .csr_raddr  (csr_raddr),
      .csr_wdata  (csr_wdata),
      .csr_rdata  (csr_rdata),
      .csr_ill    (csr_ill),
      .inh_cy     (inh_cy),
      .inh_ir     (inh_ir),
      .ovf_irq    (ovf_irq)
   );

   always #5 clk_free = ~clk_free;

   // Behavioural model: counters, event CSRs (only legal bits kept), inhibit.
   logic [63:0] cnt_m [NUM_HPM];
   logic [63:0] ev_m  [NUM_HPM];
   logic [31:0] inh_m;
   localparam logic [63:0] EV_MASK  = 64'hF000_0000_0000_00FF;
   localparam logic [31:0] INH_MASK = 32'h0000_007D;

   typedef struct {
      string       name;
      logic [63:0] rdata;
      logic        ill;
      logic        irq;
      logic        icy;
      logic        iir;
   } exp_t;

   exp_t sb[$];
   bit   probe = 1'b0;
   int   checks = 0;
   int   errors = 0;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic model_step();
      logic [63:0] nc, ne;
      int          s;
      bit          en, xinh;
      if (rst) begin
         for (int i = 0; i < NUM_HPM; i++) begin
            cnt_m[i] = '0;
            ev_m[i]  = '0;
         end
         inh_m = '0;
         return;
      end
      for (int i = 0; i < NUM_HPM; i++) begin
         s    = int'(ev_m[i][7:0]);
         xinh = (prv == 2'd0) ? ev_m[i][60] : (prv == 2'd1) ? ev_m[i][61] : ev_m[i][62];
         en   = 1'b0;
         if (s >= 1 && s <= NUM_EVT) en = evt[s-1] && !inh_m[3+i] && !xinh;
         nc = cnt_m[i];
         ne = ev_m[i];
         if (csr_wr && csr_waddr == 12'(12'hB03 + i))
            nc = rv32 ? {cnt_m[i][63:32], csr_wdata[31:0]} : csr_wdata;
         else if (csr_wr && rv32 && csr_waddr == 12'(12'hB83 + i))
            nc = {csr_wdata[31:0], cnt_m[i][31:0]};
         else if (en) begin
            nc = cnt_m[i] + 64'd1;
            if (nc == 64'd0) ne[63] = 1'b1;
         end
         if (csr_wr && csr_waddr == 12'(12'h323 + i))
            ne = rv32 ? {ne[63:32], csr_wdata[31:0] & 32'hFF} : (csr_wdata & EV_MASK);
         if (csr_wr && rv32 && csr_waddr == 12'(12'h723 + i))
            ne = {csr_wdata[31:0] & 32'hF000_0000, ne[31:0]};
         cnt_m[i] = nc;
         ev_m[i]  = ne;
      end
      if (csr_wr && csr_waddr == 12'h320) inh_m = csr_wdata[31:0] & INH_MASK;
   endtask

   function automatic logic [63:0] model_read(input logic [11:0] a);
      int          idx;
      logic [11:0] base;
      idx  = int'(a[4:0]);
      base = a & 12'hFE0;
      if (a == 12'h320) return {32'd0, inh_m};
      if (idx < 3 || idx >= 3 + NUM_HPM) return 64'd0;
      case (base)
         12'h320:          return ev_m[idx-3];
         12'h720:          return {32'd0, ev_m[idx-3][63:32]};
         12'hB00, 12'hC00: return cnt_m[idx-3];
         12'hB80, 12'hC80: return {32'd0, cnt_m[idx-3][63:32]};
         default:          return 64'd0;
      endcase
   endfunction

   function automatic logic model_ill(input logic [11:0] a, input bit wrc, input bit chk);
      int          idx;
      logic [11:0] base;
      bit          known, hi, usr;
      idx   = int'(a[4:0]);
      base  = a & 12'hFE0;
      known = (a == 12'h320) || (idx >= 3 && (base == 12'h320 || base == 12'h720 ||
              base == 12'hB00 || base == 12'hB80 || base == 12'hC00 || base == 12'hC80));
      if (!chk || !known) return 1'b0;
      hi  = (base == 12'h720) || (base == 12'hB80) || (base == 12'hC80);
      usr = (base == 12'hC00) || (base == 12'hC80);
      if (hi && !rv32) return 1'b1;
      if (usr && wrc) return 1'b1;
      if (usr && prv != 2'd3 && !mcounteren[idx]) return 1'b1;
      if (usr && prv == 2'd0 && !scounteren[idx]) return 1'b1;
      if (!usr && prv != 2'd3) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(negedge clk_free);
      model_step();
      @(posedge clk_free);
      #1;
      csr_wr = 1'b0;
      csr_rd_chk = 1'b0;
      csr_wr_chk = 1'b0;
      probe = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [63:0] d);
      csr_wr = 1'b1;
      csr_waddr = a;
      csr_wdata = d;
      tick();
   endtask

   task automatic chk_addr(input logic [11:0] a, input bit rd, input bit wrc);
      csr_waddr = a;
      csr_rd_chk = rd;
      csr_wr_chk = wrc;
   endtask

   task automatic probe_rd(input string nm, input logic [11:0] ra);
      exp_t e;
      csr_raddr = ra;
      e.name  = nm;
      e.rdata = model_read(ra);
      e.ill   = model_ill(csr_waddr, csr_wr_chk, csr_rd_chk | csr_wr_chk);
      e.irq   = ((ev_m[0][63] | ev_m[1][63]) | (ev_m[2][63] | ev_m[3][63]));
      e.icy   = inh_m[0];
      e.iir   = inh_m[2];
      sb.push_back(e);
      probe = 1'b1;
      tick();
   endtask

   task automatic probe_const(input string nm, input logic [11:0] ra, input logic [63:0] rd,
                              input bit ill, input bit irq);
      exp_t e;
      csr_raddr = ra;
      e.name  = nm;
      e.rdata = rd;
      e.ill   = ill;
      e.irq   = irq;
      e.icy   = inh_m[0];
      e.iir   = inh_m[2];
      sb.push_back(e);
      probe = 1'b1;
      tick();
   endtask

   always @(negedge clk_free) begin
      exp_t e;
      if (probe) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation, required one");
         end else begin
            e = sb.pop_front();
            check({e.name, "_rdata"}, csr_rdata, e.rdata);
            check({e.name, "_ill"}, 64'(csr_ill), 64'(e.ill));
            check({e.name, "_irq"}, 64'(ovf_irq), 64'(e.irq));
            check({e.name, "_inh"}, {62'd0, inh_ir, inh_cy}, {62'd0, e.iir, e.icy});
         end
      end
   end

   function automatic logic [11:0] rand_addr();
      logic [11:0] bases [6];
      logic [11:0] misc [4];
      int          k;
      bases = '{12'h320, 12'h720, 12'hB00, 12'hB80, 12'hC00, 12'hC80};
      misc  = '{12'h300, 12'hB02, 12'hC00, 12'hC1F};
      k = int'($urandom_range(0, 7));
      if (k == 0) return 12'h320;
      if (k == 7) return misc[$urandom_range(0, 3)];
      return bases[k-1] | 12'($urandom_range(3, 3 + NUM_HPM + 1));
   endfunction

   function automatic logic [63:0] rand_data(input logic [11:0] a);
      logic [63:0] d;
      d = {$urandom, $urandom};
      if (a == 12'h320) return 64'($urandom & $urandom & $urandom);
      case (a & 12'hFE0)
         12'h320: begin
            d[63:60] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            d[7:0]   = 8'($urandom_range(0, NUM_EVT + 2));
         end
         12'h720: d[31:28] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
         12'hB00, 12'hB80: if ($urandom_range(0, 1) == 1) d = d | 64'hFFFF_FFFF_FFFF_FFF0;
         default: ;
      endcase
      return d;
   endfunction

   initial begin
      logic [11:0] a;
      tick();
      tick();
      rst = 1'b0;

      // Reset state and basic counting
      chk_addr(12'hB03, 1'b1, 1'b0);
      probe_const("reset_cnt3", 12'hB03, 64'd0, 1'b0, 1'b0);
      wr(12'h323, 64'd1);
      evt = 16'h1;
      repeat (5) tick();
      evt = '0;
      probe_const("count5_m", 12'hB03, 64'd5, 1'b0, 1'b0);
      probe_const("count5_u", 12'hC03, 64'd5, 1'b0, 1'b0);

      // Wrap and sticky overflow, cleared by an event write
      wr(12'hB04, 64'hFFFF_FFFF_FFFF_FFFE);
      wr(12'h324, 64'd2);
      evt = 16'h2;
      repeat (3) tick();
      evt = '0;
      probe_const("wrap_cnt", 12'hB04, 64'd1, 1'b0, 1'b1);
      probe_const("wrap_of", 12'h324, 64'h8000_0000_0000_0002, 1'b0, 1'b1);
      wr(12'h324, 64'd2);
      probe_const("of_clear", 12'h324, 64'd2, 1'b0, 1'b0);

      // Privilege filtering and per-counter inhibit
      wr(12'h325, 64'h1000_0000_0000_0003);
      evt = 16'h4;
      prv = 2'd0;
      repeat (4) tick();
      prv = 2'd3;
      repeat (4) tick();
      evt = '0;
      probe_const("prv_filter", 12'hB05, 64'd4, 1'b0, 1'b0);
      wr(12'h320, 64'h20);
      evt = 16'h4;
      repeat (4) tick();
      evt = '0;
      probe_const("inhibit_frozen", 12'hB05, 64'd4, 1'b0, 1'b0);
      probe_const("inhibit_csr", 12'h320, 64'h20, 1'b0, 1'b0);
      wr(12'h320, 64'h0);

      // RV32 high-half write beats a live event
      rv32 = 1'b1;
      evt = 16'h1;
      wr(12'hB83, 64'd1);
      evt = '0;
      probe_const("rv32_hi_write", 12'hB03, 64'h1_0000_0005, 1'b0, 1'b0);
      chk_addr(12'hB83, 1'b0, 1'b1);
      probe_const("rv32_h_legal", 12'hB83, 64'd1, 1'b0, 1'b0);
      rv32 = 1'b0;
      chk_addr(12'hB83, 1'b0, 1'b1);
      probe_const("rv64_h_ill", 12'hB83, 64'd1, 1'b1, 1'b0);

      // Counter-enable gating of user shadows
      prv = 2'd1;
      mcounteren = 32'h8;
      scounteren = 32'h0;
      chk_addr(12'hC03, 1'b1, 1'b0);
      probe_const("s_mcen_ok", 12'hC03, 64'h1_0000_0005, 1'b0, 1'b0);
      chk_addr(12'h323, 1'b1, 1'b0);
      probe_const("s_mlevel_ill", 12'h323, 64'd1, 1'b1, 1'b0);
      prv = 2'd0;
      chk_addr(12'hC03, 1'b1, 1'b0);
      probe_const("u_scen_ill", 12'hC03, 64'h1_0000_0005, 1'b1, 1'b0);
      prv = 2'd3;
      chk_addr(12'hC03, 1'b0, 1'b1);
      probe_const("shadow_wr_ill", 12'hC03, 64'h1_0000_0005, 1'b1, 1'b0);
      chk_addr(12'hC1F, 1'b1, 1'b0);
      probe_const("unimpl_zero", 12'hC1F, 64'd0, 1'b0, 1'b0);

      // Write beats increment; reset mid-count
      evt = 16'h1;
      wr(12'hB03, 64'h10);
      evt = '0;
      probe_const("write_wins", 12'hB03, 64'h10, 1'b0, 1'b0);
      wr(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
      evt = 16'h3;
      tick();
      evt = '0;
      probe_const("wrap_again", 12'h324, 64'h8000_0000_0000_0002, 1'b0, 1'b1);
      evt = 16'hFFFF;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      evt = '0;
      probe_const("rst_cnt3", 12'hB03, 64'd0, 1'b0, 1'b0);
      probe_const("rst_evt4", 12'h324, 64'd0, 1'b0, 1'b0);

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         evt = NUM_EVT'($urandom);
         if ($urandom_range(0, 31) == 0) rv32 = ~rv32;
         case ($urandom_range(0, 3))
            0:       prv = 2'd0;
            1:       prv = 2'd1;
            default: prv = 2'd3;
         endcase
         mcounteren = $urandom;
         scounteren = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            a = rand_addr();
            csr_wr = 1'b1;
            csr_waddr = a;
            csr_wdata = rand_data(a);
         end else begin
            chk_addr(rand_addr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
         end
         probe_rd("rand", rand_addr());
      end

      evt = '0;
      repeat (3) tick();
      check("sb_drain", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
